// File: rtl/skinny_sbox_sched_pkg.sv
// skinny_sched_pkg
//   Shared definitions for the masked SKINNY-64 S-box sequencer:
//   - sched_state_e : sequencer states IDLE / FEED / DRAIN / FIN
//   - DEF_CELLS     : default number of 4-bit cells per round (16)
//   - DEF_SBOX_LAT  : default register depth of the masked S-box (4)
package skinny_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } sched_state_e;

  localparam int DEF_CELLS    = 16;
  localparam int DEF_SBOX_LAT = 4;

endpackage

// File: rtl/skinny_sbox_sched_if.sv
// skinny_sbox_sched_if
//   Bundle between the round controller / state memory and the S-box
//   sequencer.
//   start  : request one S-box pass over all cells (controller -> sequencer)
//   busy   : pass in progress
//   done   : one-cycle pulse after the last write-back
//   rd_idx : cell whose three shares feed the S-box this cycle
//   sb_vld : rd_idx valid, a cell enters the pipeline
//   sb_en  : per-stage S-box register enables
//   wr_en  : S-box output shares written back this cycle
//   wr_idx : destination cell of the write-back
//   Modport master = controller side, slave = sequencer side.
interface skinny_sbox_sched_if
  import skinny_sched_pkg::*;
#(
  parameter int CELLS    = DEF_CELLS,
  parameter int SBOX_LAT = DEF_SBOX_LAT,
  parameter int IDXW     = $clog2(CELLS)
);

  logic                start;
  logic                busy;
  logic                done;
  logic [IDXW-1:0]     rd_idx;
  logic                sb_vld;
  logic [SBOX_LAT-1:0] sb_en;
  logic                wr_en;
  logic [IDXW-1:0]     wr_idx;

  modport master (
    output start,
    input  busy, done, rd_idx, sb_vld, sb_en, wr_en, wr_idx
  );

  modport slave (
    input  start,
    output busy, done, rd_idx, sb_vld, sb_en, wr_en, wr_idx
  );

endinterface

// File: rtl/skinny_sbox_sched_vld_pipe.sv
// sched_vld_pipe
//   {valid, index} delay line shadowing the masked S-box pipeline. Entry 0
//   loads the cell being issued; the last entry marks the cell leaving the
//   S-box and drives the write-back strobe/index.
//   clk, rst_n : clock, asynchronous active-low reset
//   hold       : freeze every entry and suppress all enables/strobes
//   in_vld     : cell enters the S-box this cycle
//   in_idx     : index of that cell
//   sb_en      : stage enables; a stage is clocked only when a live cell
//                moves into it
//   wr_en      : write-back strobe
//   wr_idx     : write-back cell index
//   drained    : no live cell other than (possibly) the one in the last
//                entry, i.e. the line is empty after this cycle's write-back
module sched_vld_pipe #(
  parameter int LAT  = 4,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            in_vld,
  input  logic [IDXW-1:0] in_idx,
  output logic [LAT-1:0]  sb_en,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic            drained
);

  logic [LAT-1:0] vld_vec;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      logic            vld_src;
      logic [IDXW-1:0] idx_src;
      logic            vld_reg;
      logic [IDXW-1:0] idx_reg;

      if (gi == 0) begin : g_head
        assign vld_src = in_vld;
        assign idx_src = in_idx;
      end else begin : g_body
        assign vld_src = g_stage[gi-1].vld_reg;
        assign idx_src = g_stage[gi-1].idx_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg <= 1'b0;
          idx_reg <= '0;
        end else if (!hold) begin
          vld_reg <= vld_src;
          idx_reg <= idx_src;
        end
      end

      // Stage gi captures whatever sits in front of it; gating on the source
      // valid keeps stale shares from ever being re-clocked.
      assign sb_en[gi]   = vld_src & ~hold;
      assign vld_vec[gi] = vld_reg;
    end

    if (LAT == 1) begin : g_drain_one
      assign drained = 1'b1;
    end else begin : g_drain_many
      assign drained = ~|vld_vec[LAT-2:0];
    end
  endgenerate

  assign wr_en  = vld_vec[LAT-1] & ~hold;
  assign wr_idx = g_stage[LAT-1].idx_reg;

endmodule

// File: rtl/skinny_sbox_sched.sv
// skinny_sbox_sched
//   Sequencer for the shared three-share masked SKINNY-64 S-box. On start it
//   issues cells 0..CELLS-1 back to back, gates each S-box register stage so
//   only live cells are clocked, issues the write-back for each result and
//   pulses done once the pipeline has emptied.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   pause  : (only with SKINNY_SCHED_PAUSE_EN) freeze the whole block
//   sif    : slave side of skinny_sbox_sched_if (start, busy, done, rd_idx,
//            sb_vld, sb_en, wr_en, wr_idx)
//   Optional feature macro: SKINNY_SCHED_PAUSE_EN
module skinny_sbox_sched
  import skinny_sched_pkg::*;
#(
  parameter int CELLS    = DEF_CELLS,
  parameter int SBOX_LAT = DEF_SBOX_LAT,
  parameter int IDXW     = $clog2(CELLS)
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SKINNY_SCHED_PAUSE_EN
  input  logic                pause,
`endif
  skinny_sbox_sched_if.slave  sif
);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] FEED  = S_FEED;
  localparam logic [1:0] DRAIN = S_DRAIN;
  localparam logic [1:0] FIN   = S_FIN;

  localparam logic [IDXW-1:0] LAST_CELL = IDXW'(CELLS - 1);

  logic            stall;
  logic [1:0]      state_reg, state_next;
  logic [IDXW-1:0] cnt_reg, cnt_next;
  logic            feed;
  logic            issue;
  logic [IDXW-1:0] issue_idx;
  logic            drained;

`ifdef SKINNY_SCHED_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!stall) begin
      case (state_reg)
        IDLE: begin
          if (sif.start) begin
            state_next = FEED;
            cnt_next   = '0;
          end
        end
        FEED: begin
          // The counter never wraps; issuing the last cell ends the feed.
          if (cnt_reg == LAST_CELL) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + IDXW'(1);
          end
        end
        DRAIN: begin
          if (drained) begin
            state_next = FIN;
          end
        end
        FIN: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign feed      = (state_reg == FEED);
  assign issue     = feed & ~stall;
  // During a stall the counter is frozen, so rd_idx holds its value.
  assign issue_idx = feed ? cnt_reg : '0;

  sched_vld_pipe #(
    .LAT  (SBOX_LAT),
    .IDXW (IDXW)
  ) u_vld_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (stall),
    .in_vld  (issue),
    .in_idx  (issue_idx),
    .sb_en   (sif.sb_en),
    .wr_en   (sif.wr_en),
    .wr_idx  (sif.wr_idx),
    .drained (drained)
  );

  assign sif.rd_idx = issue_idx;
  assign sif.sb_vld = issue;
  assign sif.busy   = feed | (state_reg == DRAIN);
  assign sif.done   = (state_reg == FIN);

endmodule

// File: tb/tb_skinny_sbox_sched.sv
module tb_skinny_sbox_sched;

  localparam int CELLS = 16;
  localparam int LAT   = 4;
  localparam int IDXW  = 4;
  localparam int PASS_LEN = CELLS + LAT + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic pause;

  always #5 clk = ~clk;

  skinny_sbox_sched_if #(.CELLS(CELLS), .SBOX_LAT(LAT)) sif ();

  skinny_sbox_sched #(
    .CELLS    (CELLS),
    .SBOX_LAT (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SKINNY_SCHED_PAUSE_EN
    .pause (pause),
`endif
    .sif   (sif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int cyc, logic [31:0] act, int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  typedef struct {
    string name;
    int    ncyc;
    int    s_at;
    int    s_len;
    int    s2_at;
    int    rst_at;
    int    p_at;
    int    p_len;
    int    exp_dones;
    int    exp_first;
    int    exp_last;
    int    exp_wrs;
  } scn_t;

  // Reference model: a pass is just an offset d (in non-paused cycles) from
  // the cycle in which start was accepted; every output is a function of d.
  bit m_active;
  int m_d;

  task automatic run_scn(input scn_t s, input bit rnd,
                         output int dones, output int first_done,
                         output int last_done, output int wrs);
    bit st, p, rs;
    bit e_feed, e_vld, e_wr, e_busy, e_done;
    int e_rd;
    logic [LAT-1:0] e_en;
    dones = 0; first_done = -1; last_done = -1; wrs = 0;
    m_active = 1'b0; m_d = 0;
    for (int c = 0; c < s.ncyc; c++) begin
      @(negedge clk);
      if (rnd) begin
        st = ($urandom_range(0, 3) == 0);
        rs = ($urandom_range(0, 79) == 0);
`ifdef SKINNY_SCHED_PAUSE_EN
        p  = ($urandom_range(0, 4) == 0);
`else
        p  = 1'b0;
`endif
      end else begin
        st = (c >= s.s_at && c < s.s_at + s.s_len) || (c == s.s2_at);
        rs = (s.rst_at >= 0) && (c >= s.rst_at) && (c < s.rst_at + 2);
        p  = (s.p_at >= 0) && (c >= s.p_at) && (c < s.p_at + s.p_len);
      end
      sif.start = st;
      pause     = p;
      rst_n     = ~rs;
      #1;
      if (rs) m_active = 1'b0;

      e_feed = m_active && m_d >= 1 && m_d <= CELLS;
      e_vld  = e_feed && !p;
      e_rd   = e_feed ? m_d - 1 : 0;
      e_wr   = m_active && !p && m_d >= LAT + 1 && m_d <= CELLS + LAT;
      e_busy = m_active && m_d >= 1 && m_d <= CELLS + LAT;
      e_done = m_active && m_d == CELLS + LAT + 1;
      for (int i = 0; i < LAT; i++)
        e_en[i] = m_active && !p && (m_d - i >= 1) && (m_d - i <= CELLS);

      chk("busy",   c, 32'(sif.busy),   int'(e_busy));
      chk("done",   c, 32'(sif.done),   int'(e_done));
      chk("sb_vld", c, 32'(sif.sb_vld), int'(e_vld));
      chk("rd_idx", c, 32'(sif.rd_idx), e_rd);
      chk("sb_en",  c, 32'(sif.sb_en),  int'(e_en));
      chk("wr_en",  c, 32'(sif.wr_en),  int'(e_wr));
      if (e_wr) chk("wr_idx", c, 32'(sif.wr_idx), m_d - 1 - LAT);

      if (sif.done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end
      if (sif.wr_en === 1'b1) wrs++;

      @(posedge clk);
      if (!rs) begin
        if (m_active) begin
          if (!p) begin
            m_d++;
            if (m_d == PASS_LEN) m_active = 1'b0;
          end
        end else if (st && !p) begin
          m_active = 1'b1;
          m_d      = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sif.start = 1'b0; pause = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  scn_t tbl[7];
  int   n_rows;
  scn_t rnd_s;
  int   dn, fd, ld, wr;

  initial begin
    sif.start = 1'b0;
    pause     = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",   -1, 32'(sif.busy),   0);
    chk("rst_done",   -1, 32'(sif.done),   0);
    chk("rst_sb_vld", -1, 32'(sif.sb_vld), 0);
    chk("rst_wr_en",  -1, 32'(sif.wr_en),  0);
    chk("rst_sb_en",  -1, 32'(sif.sb_en),  0);
    chk("rst_rd_idx", -1, 32'(sif.rd_idx), 0);
    chk("rst_wr_idx", -1, 32'(sif.wr_idx), 0);
    rst_n = 1'b1;

    //          name        ncyc s_at s_len s2  rst  p_at p_len dones first last wrs
    tbl[0] = '{"idle",        10,  -1,  0,  -1,  -1,  -1,  0,   0,   -1,  -1,   0};
    tbl[1] = '{"single",      30,   0,  1,  -1,  -1,  -1,  0,   1,   21,  21,  16};
    tbl[2] = '{"held",        60,   0, 60,  -1,  -1,  -1,  0,   2,   21,  43,  43};
    tbl[3] = '{"restart_ign", 30,   0,  1,   8,  -1,  -1,  0,   1,   21,  21,  16};
    tbl[4] = '{"back2back",   50,   0,  1,  22,  -1,  -1,  0,   2,   21,  43,  32};
    tbl[5] = '{"rst_mid",     40,   0,  1,  15,  10,  -1,  0,   1,   36,  36,  21};
    n_rows = 6;
`ifdef SKINNY_SCHED_PAUSE_EN
    tbl[6] = '{"pause",       30,   0,  1,  -1,  -1,   6,  3,   1,   24,  24,  16};
    n_rows = 7;
`endif

    for (int r = 0; r < n_rows; r++) begin
      do_reset();
      run_scn(tbl[r], 1'b0, dn, fd, ld, wr);
      chk({tbl[r].name, "_dones"}, r, 32'(dn), tbl[r].exp_dones);
      chk({tbl[r].name, "_first"}, r, 32'(fd), tbl[r].exp_first);
      chk({tbl[r].name, "_last"},  r, 32'(ld), tbl[r].exp_last);
      chk({tbl[r].name, "_wrs"},   r, 32'(wr), tbl[r].exp_wrs);
      $display("scenario %s: dones=%0d first=%0d last=%0d wrs=%0d",
               tbl[r].name, dn, fd, ld, wr);
    end

    rnd_s = '{"random", 300, -1, 0, -1, -1, -1, 0, 0, 0, 0, 0};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_scn(rnd_s, 1'b1, dn, fd, ld, wr);
      $display("random run %0d: dones=%0d wrs=%0d", k, dn, wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
